// File: rtl/rpn_pkg.sv
// Shared definitions for the infix-to-postfix converter: token codes,
// operator precedence and FSM state encoding.
package rpn_pkg;

  localparam int unsigned CODE_W = 3;

  localparam logic [CODE_W-1:0] TOK_ADD    = 3'd0;
  localparam logic [CODE_W-1:0] TOK_SUB    = 3'd1;
  localparam logic [CODE_W-1:0] TOK_MUL    = 3'd2;
  localparam logic [CODE_W-1:0] TOK_DIV    = 3'd3;
  localparam logic [CODE_W-1:0] TOK_EQ     = 3'd4;
  localparam logic [CODE_W-1:0] TOK_LPAREN = 3'd5;
  localparam logic [CODE_W-1:0] TOK_RPAREN = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT_NUM,
    ST_REDUCE,
    ST_PUSH,
    ST_UNWIND,
    ST_FLUSH,
    ST_EMIT_EQ,
    ST_ERR
  } state_e;

  // LPAREN (and anything else) ranks lowest so it is never popped by precedence.
  function automatic logic [1:0] prec(input logic [CODE_W-1:0] code);
    case (code)
      TOK_ADD, TOK_SUB: prec = 2'd1;
      TOK_MUL, TOK_DIV: prec = 2'd2;
      default:          prec = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/op_stack.sv
// LIFO holding pending operator codes; top is a combinational peek.
module op_stack #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign top   = empty ? '0 : mem_q[AW'(cnt_q - CW'(1))];

  // Clear wins; push and pop are never requested together by the FSM.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (push && !full) begin
      mem_d[AW'(cnt_q)] = din;
      cnt_d             = cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/infix_to_postfix.sv
// Shunting-yard converter: turns an infix token stream into postfix tokens
// on a registered strobe/ack handshake toward the calculator.
module infix_to_postfix
  import rpn_pkg::*;
#(
  parameter int unsigned OP_DEPTH = 16,
  parameter int unsigned WIDTH    = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_stb,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_is_op,
  output logic             in_ack,
  output logic             out_stb,
  output logic [WIDTH-1:0] out_data,
  output logic             out_is_op,
  input  logic             out_ack,
  output logic             error,
  output logic             busy
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  tok_q, tok_d;
  logic              out_stb_q, out_stb_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_is_op_q, out_is_op_d;
  logic              in_ack_q, in_ack_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;

  logic              stk_push, stk_pop, stk_clear;
  logic [CODE_W-1:0] stk_top;
  logic              stk_empty, stk_full;
  logic [CODE_W-1:0] tok_code;
  logic              in_take;

  assign tok_code = tok_q[CODE_W-1:0];
  // The cycle after an ack, upstream may still show the consumed token.
  assign in_take  = in_stb && !in_ack_q;

  op_stack #(
    .WIDTH (CODE_W),
    .DEPTH (OP_DEPTH)
  ) u_op_stack (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (stk_push),
    .pop   (stk_pop),
    .clear (stk_clear),
    .din   (tok_code),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

  always_comb begin
    state_d     = state_q;
    tok_d       = tok_q;
    out_stb_d   = out_stb_q;
    out_data_d  = out_data_q;
    out_is_op_d = out_is_op_q;
    in_ack_d    = 1'b0;
    error_d     = error_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_take) begin
          tok_d = in_data;
          if (!in_is_op) begin
            state_d = ST_EMIT_NUM;
          end else begin
            case (in_data[CODE_W-1:0])
              TOK_ADD, TOK_SUB, TOK_MUL, TOK_DIV: state_d = ST_REDUCE;
              TOK_LPAREN:                         state_d = ST_PUSH;
              TOK_RPAREN:                         state_d = ST_UNWIND;
              TOK_EQ:                             state_d = ST_FLUSH;
              default: begin
                state_d  = ST_ERR;
                error_d  = 1'b1;
                in_ack_d = 1'b1;
              end
            endcase
          end
        end
      end

      ST_EMIT_NUM: begin
        if (!out_stb_q) begin
          out_stb_d   = 1'b1;
          out_data_d  = tok_q;
          out_is_op_d = 1'b0;
        end else if (out_ack) begin
          out_stb_d = 1'b0;
          in_ack_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_REDUCE: begin
        if (out_stb_q) begin
          if (out_ack) out_stb_d = 1'b0;
        end else if (!stk_empty && (prec(stk_top) >= prec(tok_code))) begin
          stk_pop     = 1'b1;
          out_stb_d   = 1'b1;
          out_data_d  = WIDTH'(stk_top);
          out_is_op_d = 1'b1;
        end else begin
          state_d = ST_PUSH;
        end
      end

      ST_PUSH: begin
        in_ack_d = 1'b1;
        if (stk_full) begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end else begin
          stk_push = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      ST_UNWIND: begin
        if (out_stb_q) begin
          if (out_ack) out_stb_d = 1'b0;
        end else if (stk_empty) begin
          state_d  = ST_ERR;
          error_d  = 1'b1;
          in_ack_d = 1'b1;
        end else if (stk_top == TOK_LPAREN) begin
          stk_pop  = 1'b1;
          in_ack_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          stk_pop     = 1'b1;
          out_stb_d   = 1'b1;
          out_data_d  = WIDTH'(stk_top);
          out_is_op_d = 1'b1;
        end
      end

      // EQ is launched straight from here so it follows the last pop with a one-cycle gap.
      ST_FLUSH: begin
        if (out_stb_q) begin
          if (out_ack) out_stb_d = 1'b0;
        end else if (stk_empty) begin
          out_stb_d   = 1'b1;
          out_data_d  = WIDTH'(TOK_EQ);
          out_is_op_d = 1'b1;
          state_d     = ST_EMIT_EQ;
        end else if (stk_top == TOK_LPAREN) begin
          state_d  = ST_ERR;
          error_d  = 1'b1;
          in_ack_d = 1'b1;
        end else begin
          stk_pop     = 1'b1;
          out_stb_d   = 1'b1;
          out_data_d  = WIDTH'(stk_top);
          out_is_op_d = 1'b1;
        end
      end

      ST_EMIT_EQ: begin
        if (out_stb_q && out_ack) begin
          out_stb_d = 1'b0;
          in_ack_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      // The offending token was acked on entry; later tokens are dropped until an EQ resyncs.
      ST_ERR: begin
        stk_clear = 1'b1;
        error_d   = 1'b1;
        if (in_take) begin
          in_ack_d = 1'b1;
          if (in_is_op && (in_data[CODE_W-1:0] == TOK_EQ)) begin
            error_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      tok_q       <= '0;
      out_stb_q   <= 1'b0;
      out_data_q  <= '0;
      out_is_op_q <= 1'b0;
      in_ack_q    <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tok_q       <= tok_d;
      out_stb_q   <= out_stb_d;
      out_data_q  <= out_data_d;
      out_is_op_q <= out_is_op_d;
      in_ack_q    <= in_ack_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ack    = in_ack_q;
  assign out_stb   = out_stb_q;
  assign out_data  = out_data_q;
  assign out_is_op = out_is_op_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule

// File: doc/infix_to_postfix.md
# infix_to_postfix

Shunting-yard converter that sits directly upstream of `calculator`. It accepts an infix token stream with parentheses and operator precedence, and emits the equivalent postfix (RPN) token stream on `calculator`'s input handshake. Numbers pass straight through. Operators and parentheses are held in an internal operator stack and released according to precedence. `=` flushes all pending operators and is then forwarded.

## Interface
- `OP_DEPTH`, 16: operator-stack entries. Each entry is a 3-bit token code.
- `WIDTH`, 32: data width.
- `CLK` in 1: clock. All logic is on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `in_stb` in 1: an upstream token is valid. Held until `in_ack`.
- `in_data` in WIDTH: number, or token code in [2:0] when `in_is_op`=1.
- `in_is_op` in 1: 1 = operator/paren/`=`, 0 = number.
- `in_ack` out 1: one-cycle pulse; the token is fully consumed.
- `out_stb` out 1: downstream token valid. Connects to `calculator.input_stb`.
- `out_data` out WIDTH: number, or operator code zero-extended. Connects to `input_data`.
- `out_is_op` out 1: connects to `is_input_operator`.
- `out_ack` in 1: connects to `calculator.input_ack`.
- `error` out 1: sticky syntax/overflow flag.
- `busy` out 1: high whenever the FSM is not in IDLE.

Token codes: ADD=0, SUB=1, MUL=2, DIV=3, EQ=4, LPAREN=5, RPAREN=6, 7=illegal. Only codes 0–4 are ever emitted.

## Operation
- Precedence: ADD and SUB = 1; MUL and DIV = 2; LPAREN = 0 (never popped by precedence). All operators are left-associative.
- FSM states:
  - IDLE: wait for `in_stb`. Number → EMIT_NUM. ADD/SUB/MUL/DIV → REDUCE. LPAREN → PUSH. RPAREN → UNWIND. EQ → FLUSH. Code 7 → ERR.
  - EMIT_NUM: drive `in_data` downstream and wait for the handshake. After `out_ack`, pulse `in_ack` → IDLE.
  - REDUCE: if the stack is non-empty and prec(top) ≥ prec(incoming), pop and emit the top and wait for the handshake, then re-evaluate. Otherwise → PUSH.
  - PUSH: if the stack is full → ERR. Otherwise push the code, pulse `in_ack` → IDLE.
  - UNWIND:
    - Top is LPAREN: pop it, do not emit, pulse `in_ack` → IDLE.
    - Stack is empty: → ERR (unmatched `)`).
    - Otherwise: pop and emit the top, wait for the handshake, stay in UNWIND.
  - FLUSH:
    - Top is LPAREN: → ERR (unmatched `(`).
    - Stack is non-empty: pop and emit the top, wait for the handshake, stay in FLUSH.
    - Stack is empty: → EMIT_EQ.
  - EMIT_EQ: emit EQ and wait for `out_ack`, pulse `in_ack` → IDLE.
  - ERR: set `error`, clear the stack, and acknowledge and discard every token.
    - The first token taken in ERR is acknowledged and dropped.
    - On an EQ token: ack it, do not forward it, clear `error` → IDLE.
- Number values are forwarded unmodified. No arithmetic is performed in this block.

## Timing
- Reset values: `out_stb`=0, `out_data`=0, `out_is_op`=0, `in_ack`=0, `error`=0, `busy`=0. The stack is empty and the FSM is in IDLE.
- Downstream handshake:
  - `out_stb`, `out_data` and `out_is_op` are registered and stay stable until `out_ack` is sampled high.
  - `out_stb` drops on the edge that samples `out_ack`. It stays low for at least one full cycle before the next assertion, so the consumer never re-reads a stale token.
- Latency: number in_stb sampled at edge N → `out_stb` high after edge N+1. `in_ack` pulses one cycle after `out_ack` is sampled.
- Upstream: `in_ack` is a single-cycle pulse. Upstream must drop `in_stb` or change the token on the next cycle. `in_data` and `in_is_op` are captured into a token register in IDLE.
- Each pop+emit costs one handshake; there is no added bubble between successive pops beyond the mandatory one-cycle `out_stb` low.
- Simultaneous stack pop and push never occur; the FSM serializes them.
- `RST_N` low mid-stream: everything returns to reset values immediately. A partial expression is lost, and any pending `out_stb` is dropped.

## Structure
- Shared package `rpn_pkg`:
  - token-code localparams (ADD…RPAREN);
  - a `prec()` function;
  - FSM state encoding.
- Sub-module `op_stack`: a LIFO with parameters WIDTH=3 and DEPTH=OP_DEPTH.
  - Ports: push, pop, clear, top (combinational peek), empty, full.
  - Reset: asynchronous active-low.
- Top level: FSM plus the token register. Target size about 200 lines.

## Test plan
- `3 + 4 * 2 =` → `3, 4, 2, MUL, ADD, EQ`. With `calculator` attached, `output_data` = 11.
- `( 3 + 4 ) * 2 =` → `3, 4, ADD, 2, MUL, EQ`. Result = 14. LPAREN is never emitted.
- `8 - 3 - 2 =` → `8, 3, SUB, 2, SUB, EQ`. Result = 3, which checks left associativity.
- `out_ack` held low for 5 cycles on each token → `out_stb` and `out_data` are stable throughout, with exactly one cycle of `out_stb` low between tokens.
- Unmatched parentheses:
  - `3 ) + 1 =` → `error` rises after `)`. `+`, `1` and `=` are acked and dropped, nothing further is emitted, and `error` clears after `=`.
  - `( 2 =` behaves the same way, with the error raised at `=`.
- 17 consecutive LPANREN tokens with OP_DEPTH=16 → `error` on the 17th.
- Reset mid-op: assert `RST_N` low during FLUSH → all outputs are 0 next cycle and the stack is empty. `5 =` then yields `5, EQ`.
